// File: rtl/l1_i_controller.sv
// L1 instruction cache controller: tag store, valid bits and the
// lookup / miss-allocate sequencing between the core fetch port and L2.
// The data array lives in the datapath; this block only tells it when to
// write a refilled line (refill) or deliver a hit word (update).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a fetch; latches tag/index on read_C_L1
// COMPARE  | tag lookup on the latched request; hit -> update, miss -> ALLOCATE
// ALLOCATE | line requested from L2; waits for ready_L2_L1, then refills
module l1_i_controller #(
   parameter int TAG_W = 52,
   parameter int IDX_W = 6,
   parameter int SETS  = 64
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [TAG_W-1:0] tag,
   input  logic [IDX_W-1:0] index,
   input  logic             read_C_L1,
   input  logic             ready_L2_L1,
   input  logic             flush,
   output logic             stall,
   output logic             refill,
   output logic             update,
   output logic             read_L1_L2,
   output logic             write_L1_L2
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      COMPARE  = 2'b01,
      ALLOCATE = 2'b10
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_ram [SETS];
   logic [TAG_W-1:0] req_tag_q;
   logic [IDX_W-1:0] req_idx_q;

   logic             hit;
   logic             latch_req;
   logic             fill;

   // Read-only cache: lines are never dirty, so no write-back is ever issued.
   assign write_L1_L2 = 1'b0;

   assign hit = valid_q[req_idx_q] && (tag_ram[req_idx_q] == req_tag_q);

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode; flush overrides everything and
   // abandons any in-flight miss.
   always_comb begin
      state_d    = state_q;
      stall      = 1'b0;
      refill     = 1'b0;
      update     = 1'b0;
      read_L1_L2 = 1'b0;
      latch_req  = 1'b0;
      fill       = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (read_C_L1) begin
                  latch_req = 1'b1;
                  state_d   = COMPARE;
               end
            end
            COMPARE: begin
               if (hit) begin
                  update  = 1'b1;
                  state_d = IDLE;
               end else begin
                  stall   = 1'b1;
                  state_d = ALLOCATE;
               end
            end
            ALLOCATE: begin
               stall      = 1'b1;
               read_L1_L2 = 1'b1;
               if (ready_L2_L1) begin
                  refill  = 1'b1;
                  fill    = 1'b1;
                  state_d = COMPARE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Request registers: only a fetch accepted in IDLE is captured.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         req_tag_q <= '0;
         req_idx_q <= '0;
      end else if (latch_req) begin
         req_tag_q <= tag;
         req_idx_q <= index;
      end
   end

   // Valid bits: flush clears all lines, a refill validates one.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (fill) begin
         valid_q[req_idx_q] <= 1'b1;
      end
   end

   // Tag store; contents are meaningless until the matching valid bit is set,
   // so it carries no reset.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_ram[req_idx_q] <= req_tag_q;
      end
   end

endmodule

// File: tb/tb_l1_i_controller.sv
// Bench for l1_i_controller: directed fetches push the expected outcome
// (hit/miss and number of L2 request cycles) into a queue; a monitor pops
// and compares whenever the DUT pulses update.
module tb_l1_i_controller;

   localparam int TAG_W = 52;
   localparam int IDX_W = 6;

   logic             clk;
   logic             nrst;
   logic [TAG_W-1:0] tag;
   logic [IDX_W-1:0] index;
   logic             read_C_L1;
   logic             ready_L2_L1;
   logic             flush;
   logic             stall;
   logic             refill;
   logic             update;
   logic             read_L1_L2;
   logic             write_L1_L2;

   typedef struct packed {
      bit miss;
      int n_read;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   errors;
   int   mon_read;
   int   mon_refill;

   localparam logic [TAG_W-1:0] T1 = 52'hFF00FF00FFFFF;
   localparam logic [TAG_W-1:0] T2 = 52'h0000FF00FFFFF;
   localparam logic [TAG_W-1:0] T3 = 52'h123456789ABCD;
   localparam logic [TAG_W-1:0] T4 = 52'h00000000000AA;
   localparam logic [TAG_W-1:0] T5 = 52'hFFFFFFFFFFFFF;

   l1_i_controller dut (
      .clk         (clk),
      .nrst        (nrst),
      .tag         (tag),
      .index       (index),
      .read_C_L1   (read_C_L1),
      .ready_L2_L1 (ready_L2_L1),
      .flush       (flush),
      .stall       (stall),
      .refill      (refill),
      .update      (update),
      .read_L1_L2  (read_L1_L2),
      .write_L1_L2 (write_L1_L2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string name, input logic [3:0] exp);
      chk({name, " outs(stall,refill,update,rd)"}, int'({stall, refill, update, read_L1_L2}), int'(exp));
   endtask

   // One complete fetch; for a miss, L2 holds ready low for l2_delay cycles.
   task automatic fetch(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i,
                        input bit miss, input int l2_delay);
      exp_t e;
      e.miss   = miss;
      e.n_read = miss ? l2_delay + 1 : 0;
      sb.push_back(e);
      tag       = t;
      index     = i;
      read_C_L1 = 1'b1;
      tick();
      read_C_L1 = 1'b0;
      tag       = ~t;
      index     = i + 6'd1;
      if (miss) begin
         tick();
         for (int k = 0; k < l2_delay; k++) tick();
         ready_L2_L1 = 1'b1;
         tick();
         ready_L2_L1 = 1'b0;
         tick();
      end else begin
         ready_L2_L1 = 1'b1;
         read_C_L1   = 1'b1;
         tick();
         ready_L2_L1 = 1'b0;
         read_C_L1   = 1'b0;
      end
   endtask

   // Drives a fetch that is known to miss, leaving the DUT in ALLOCATE.
   task automatic start_miss(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
      tag       = t;
      index     = i;
      read_C_L1 = 1'b1;
      tick();
      read_C_L1 = 1'b0;
      #1 chk_outs("compare_miss", 4'b1000);
      tick();
      #1 chk_outs("allocate_wait", 4'b1001);
   endtask

   // Monitor: tallies L2 request/refill cycles and scores each update pulse.
   always @(negedge clk) begin
      exp_t e;
      if (nrst) begin
         chk("write_L1_L2", int'(write_L1_L2), 0);
      end
      if (!nrst || flush) begin
         mon_read   = 0;
         mon_refill = 0;
      end else begin
         if (read_L1_L2) mon_read++;
         if (refill) mon_refill++;
         if (update) begin
            if (sb.size() == 0) begin
               chk("unexpected_update", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("miss", int'(mon_refill > 0), int'(e.miss));
               chk("l2_read_cycles", mon_read, e.n_read);
               chk("stall_on_update", int'(stall), 0);
            end
            mon_read   = 0;
            mon_refill = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      mon_read    = 0;
      mon_refill  = 0;
      nrst        = 1'b0;
      tag         = '0;
      index       = '0;
      read_C_L1   = 1'b0;
      ready_L2_L1 = 1'b0;
      flush       = 1'b0;
      tick();
      tick();
      chk_outs("reset", 4'b0000);
      nrst = 1'b1;
      tick();
      chk_outs("idle", 4'b0000);

      // Cold miss, hit, conflict eviction and re-miss.
      fetch(T1, 6'd13, 1'b1, 0);
      fetch(T1, 6'd13, 1'b0, 0);
      fetch(T2, 6'd13, 1'b1, 0);
      fetch(T1, 6'd13, 1'b1, 0);
      fetch(T1, 6'd13, 1'b0, 0);
      fetch(T1, 6'd14, 1'b1, 0);

      // Slow L2.
      fetch(T3, 6'd5, 1'b1, 3);
      fetch(T3, 6'd5, 1'b0, 0);

      // Fill idx 0, flush in IDLE, then everything misses.
      fetch(T2, 6'd0, 1'b1, 1);
      fetch(T2, 6'd0, 1'b0, 0);
      flush = 1'b1;
      #1 chk_outs("flush_idle", 4'b0000);
      tick();
      flush = 1'b0;
      fetch(T1, 6'd13, 1'b1, 0);
      fetch(T2, 6'd0, 1'b1, 0);
      fetch(T3, 6'd5, 1'b1, 0);
      fetch(T1, 6'd13, 1'b0, 0);

      // Flush during ALLOCATE with L2 ready in the same cycle: no refill.
      start_miss(T4, 6'd20);
      flush       = 1'b1;
      ready_L2_L1 = 1'b1;
      #1 chk_outs("flush_alloc", 4'b0000);
      tick();
      flush       = 1'b0;
      ready_L2_L1 = 1'b0;
      #1 chk_outs("after_flush", 4'b0000);
      fetch(T4, 6'd20, 1'b1, 0);

      // Async reset between edges mid-miss.
      start_miss(T5, 6'd7);
      #2 nrst = 1'b0;
      #1 chk_outs("async_reset", 4'b0000);
      tick();
      tick();
      nrst = 1'b1;
      tick();
      fetch(T1, 6'd13, 1'b1, 0);
      fetch(T5, 6'd7, 1'b1, 2);
      fetch(T5, 6'd7, 1'b0, 0);

      tick();
      tick();
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
